// File: rtl/serial_pattern_counter.sv
// Loads a parallel word, scans it LSB first and counts occurrences of PATTERN.
// Overlapping matches are counted only when OVERLAP is 1.
module serial_pattern_counter #(
  parameter int                 DATA_W  = 16,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              match,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_shreg;
  logic [PAT_LEN-1:0]  r_hist;
  logic [FILL_W-1:0]   r_fill;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_count;
  logic                r_match;

  logic                w_load;
  logic                w_shift;
  logic [PAT_LEN-1:0]  w_hist_next;
  logic [FILL_W-1:0]   w_fill_next;
  logic                w_hit;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (en) w_state_next = SHIFT;
      SHIFT:   if (r_idx == IDX_LAST) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_load      = (r_state == IDLE) && en;
  assign w_shift     = (r_state == SHIFT);
  assign w_hist_next = {r_hist[PAT_LEN-2:0], r_shreg[0]};
  assign w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
  // A hit needs a full window of bits seen since load (or since the last hit when not overlapping).
  assign w_hit       = w_shift && (w_hist_next == PATTERN) && (w_fill_next == FILL_FULL);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_shreg <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_load) begin
        r_shreg <= din;
        r_hist  <= '0;
        r_fill  <= '0;
        r_idx   <= '0;
        r_count <= '0;
      end else if (w_shift) begin
        r_shreg <= {1'b0, r_shreg[DATA_W-1:1]};
        r_hist  <= w_hist_next;
        r_fill  <= (w_hit && (OVERLAP == 0)) ? '0 : w_fill_next;
        r_idx   <= r_idx + 1'b1;
        if (w_hit && (r_count != '1)) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign busy  = (r_state == SHIFT);
  assign done  = (r_state == DONE);
  assign match = r_match;
  assign count = r_count;

endmodule
